// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file.
// Two write ports (port 1 has priority), NUM_RD combinational read ports,
// optional hardwired-zero register 0, optional write-to-read bypass, and a
// per-register busy scoreboard for multi-cycle producers.
// Reset is asynchronous active-low; it clears every register and every busy
// bit, and it forces all outputs to zero while asserted.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     busy_any
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // Register storage and busy scoreboard, all in flops.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;

    // Write/issue requests after dropping accesses to the hardwired zero register.
    logic wr0_ok;
    logic wr1_ok;
    logic iss_ok;

    // One-hot decoded per-register strobes.
    logic [DEPTH-1:0] wr0_hit;
    logic [DEPTH-1:0] wr1_hit;
    logic [DEPTH-1:0] iss_hit;

    // Qualify requests: with ZERO_REG set, anything aimed at register 0 is ignored.
    always_comb begin
        wr0_ok = we0;
        wr1_ok = we1;
        iss_ok = iss_en;
        if (ZERO_REG != 0) begin
            if (waddr0 == '0) begin
                wr0_ok = 1'b0;
            end
            if (waddr1 == '0) begin
                wr1_ok = 1'b0;
            end
            if (iss_addr == '0) begin
                iss_ok = 1'b0;
            end
        end
    end

    // Decode the qualified requests into per-register strobes.
    always_comb begin
        wr0_hit = '0;
        wr1_hit = '0;
        iss_hit = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wr0_hit[i] = wr0_ok && (waddr0 == ADDR_W'(i));
            wr1_hit[i] = wr1_ok && (waddr1 == ADDR_W'(i));
            iss_hit[i] = iss_ok && (iss_addr == ADDR_W'(i));
        end
    end

    // Register update: port 1 wins when both ports target the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr1_hit[i]) begin
                    mem[i] <= wdata1;
                end else if (wr0_hit[i]) begin
                    mem[i] <= wdata0;
                end
            end
        end
    end

    // Scoreboard update: an issue on the same edge as a write keeps the register
    // busy, since the newly issued producer supersedes the completing one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (iss_hit[i]) begin
                    busy[i] <= 1'b1;
                end else if (wr0_hit[i] || wr1_hit[i]) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Aggregate busy flag from registered state only (never bypassed).
    always_comb begin
        busy_any = rst_n && (|busy);
    end

    // Read ports: combinational lookup with optional same-cycle forwarding.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              rb;
        logic              is_zero;
        logic              byp1;
        logic              byp0;

        assign ra = raddr[k*ADDR_W +: ADDR_W];

        // Select stored value, forwarded write data, or zero for this port.
        always_comb begin
            is_zero = (ZERO_REG != 0) && (ra == '0);
            byp1    = (BYPASS != 0) && we1 && (waddr1 == ra);
            byp0    = (BYPASS != 0) && we0 && (waddr0 == ra);
            rd      = mem[ra];
            rb      = busy[ra];
            if (!rst_n || is_zero) begin
                rd = '0;
                rb = 1'b0;
            end else if (byp1) begin
                rd = wdata1;
                rb = 1'b0;
            end else if (byp0) begin
                rd = wdata0;
                rb = 1'b0;
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = rd;
        assign rbusy[k]                  = rb;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed, table-driven bench for regfile_mp.
// Three 32-bit instances share one stimulus (default, BYPASS=0, ZERO_REG=0);
// a fourth 16-bit / 4-read-port instance is driven separately.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic        we0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        we1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic [9:0]  raddr;
    logic        iss_en;
    logic [4:0]  iss_addr;

    logic [63:0] rdata_def, rdata_nob, rdata_noz;
    logic [1:0]  rbusy_def, rbusy_nob, rbusy_noz;
    logic        any_def, any_nob, any_noz;

    logic        w_we0;
    logic [2:0]  w_waddr0;
    logic [15:0] w_wdata0;
    logic        w_we1;
    logic [2:0]  w_waddr1;
    logic [15:0] w_wdata1;
    logic [11:0] w_raddr;
    logic [63:0] w_rdata;
    logic [3:0]  w_rbusy;
    logic        w_iss_en;
    logic [2:0]  w_iss_addr;
    logic        w_any;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_mp u_def (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_def), .rbusy(rbusy_def),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_any(any_def)
    );

    regfile_mp #(.BYPASS(0)) u_nob (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_nob), .rbusy(rbusy_nob),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_any(any_nob)
    );

    regfile_mp #(.ZERO_REG(0)) u_noz (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_noz), .rbusy(rbusy_noz),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_any(any_noz)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) u_wide (
        .clk(clk), .rst_n(rst_n),
        .we0(w_we0), .waddr0(w_waddr0), .wdata0(w_wdata0),
        .we1(w_we1), .waddr1(w_waddr1), .wdata1(w_wdata1),
        .raddr(w_raddr), .rdata(w_rdata), .rbusy(w_rbusy),
        .iss_en(w_iss_en), .iss_addr(w_iss_addr), .busy_any(w_any)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iss;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
        logic        any;
        logic [31:0] nob_d0;
        logic        nob_b0;
        logic [31:0] noz_d0;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        iss_en = 1'b0; iss_addr = '0;
    endtask

    initial begin
        logic [2:0] sel [4];

        // Records: writes, issue, read addresses, then expected outputs of the
        // default instance followed by the BYPASS=0 and ZERO_REG=0 port-0 values.
        tbl[0]  = '{1,7,'h11, 1,7,'h22, 0,0, 7,7,   'h22,'h22,       0,0,0, 'h0,0,'h22};
        tbl[1]  = '{0,0,0, 0,0,0, 0,0, 7,0,         'h22,0,          0,0,0, 'h22,0,'h22};
        tbl[2]  = '{1,0,'hFFFFFFFF, 0,0,0, 1,0, 0,7,0,'h22,          0,0,0, 0,0,'hFFFFFFFF};
        tbl[3]  = '{0,0,0, 0,0,0, 0,0, 0,3,         0,0,             0,0,0, 0,0,'hFFFFFFFF};
        tbl[4]  = '{1,3,'h1234, 0,0,0, 0,0, 3,7,    'h1234,'h22,     0,0,0, 0,0,'h1234};
        tbl[5]  = '{0,0,0, 0,0,0, 0,0, 3,0,         'h1234,0,        0,0,0, 'h1234,0,'h1234};
        tbl[6]  = '{0,0,0, 0,0,0, 1,9, 9,3,         0,'h1234,        0,0,0, 0,0,0};
        tbl[7]  = '{0,0,0, 0,0,0, 0,0, 9,3,         0,'h1234,        1,0,1, 0,1,0};
        tbl[8]  = '{0,0,0, 1,9,'h55, 0,0, 9,9,      'h55,'h55,       0,0,1, 0,1,'h55};
        tbl[9]  = '{0,0,0, 0,0,0, 0,0, 9,7,         'h55,'h22,       0,0,0, 'h55,0,'h55};
        tbl[10] = '{1,9,'h77, 0,0,0, 1,9, 9,0,      'h77,0,          0,0,0, 'h55,0,'h77};
        tbl[11] = '{0,0,0, 0,0,0, 0,0, 9,9,         'h77,'h77,       1,1,1, 'h77,1,'h77};
        tbl[12] = '{0,0,0, 0,0,0, 1,9, 9,9,         'h77,'h77,       1,1,1, 'h77,1,'h77};
        tbl[13] = '{0,0,0, 0,0,0, 0,0, 9,3,         'h77,'h1234,     1,0,1, 'h77,1,'h77};
        tbl[14] = '{1,10,'hA0A0, 1,11,'hB1B1, 0,0, 10,11, 'hA0A0,'hB1B1, 0,0,1, 0,0,'hA0A0};
        tbl[15] = '{0,0,0, 0,0,0, 0,0, 10,11,       'hA0A0,'hB1B1,   0,0,1, 'hA0A0,0,'hA0A0};
        tbl[16] = '{1,9,'h99, 0,0,0, 0,0, 9,11,     'h99,'hB1B1,     0,0,1, 'h77,1,'h99};
        tbl[17] = '{0,0,0, 0,0,0, 0,0, 9,10,        'h99,'hA0A0,     0,0,0, 'h99,0,'h99};

        rst_n = 1'b0;
        idle();
        raddr = '0;
        w_we0 = 1'b0; w_waddr0 = '0; w_wdata0 = '0;
        w_we1 = 1'b0; w_waddr1 = '0; w_wdata1 = '0;
        w_raddr = '0; w_iss_en = 1'b0; w_iss_addr = '0;

        // Reset holds outputs at zero even with a bypassable write pending.
        we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'hAA;
        raddr = {5'd0, 5'd5};
        #2;
        chk("rst_rdata_bypass", rdata_def[31:0], 64'h0);
        chk("rst_rbusy", {62'h0, rbusy_def}, 64'h0);
        chk("rst_busy_any", {63'h0, any_def}, 64'h0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle();
        tick();

        // Write r5 and mark it busy, then assert reset mid-cycle.
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        iss_en = 1'b1; iss_addr = 5'd5;
        tick();
        idle();
        raddr = {5'd0, 5'd5};
        #1;
        chk("pre_rst_r5", rdata_def[31:0], 64'hDEADBEEF);
        chk("pre_rst_rbusy5", {63'h0, rbusy_def[0]}, 64'h1);
        chk("pre_rst_any", {63'h0, any_def}, 64'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_r5", rdata_def[31:0], 64'h0);
        chk("mid_rst_rbusy5", {63'h0, rbusy_def[0]}, 64'h0);
        chk("mid_rst_any", {63'h0, any_def}, 64'h0);
        chk("mid_rst_nob_r5", rdata_nob[31:0], 64'h0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_r5", rdata_def[31:0], 64'h0);
        chk("post_rst_any", {63'h0, any_def}, 64'h0);

        // Table of single-cycle vectors; outputs compared before each edge.
        for (int i = 0; i < 18; i++) begin
            we0 = tbl[i].we0; waddr0 = tbl[i].wa0; wdata0 = tbl[i].wd0;
            we1 = tbl[i].we1; waddr1 = tbl[i].wa1; wdata1 = tbl[i].wd1;
            iss_en = tbl[i].iss; iss_addr = tbl[i].ia;
            raddr = {tbl[i].ra1, tbl[i].ra0};
            #1;
            chk($sformatf("v%0d_d0", i), rdata_def[31:0], 64'(tbl[i].d0));
            chk($sformatf("v%0d_d1", i), rdata_def[63:32], 64'(tbl[i].d1));
            chk($sformatf("v%0d_b0", i), {63'h0, rbusy_def[0]}, {63'h0, tbl[i].b0});
            chk($sformatf("v%0d_b1", i), {63'h0, rbusy_def[1]}, {63'h0, tbl[i].b1});
            chk($sformatf("v%0d_any", i), {63'h0, any_def}, {63'h0, tbl[i].any});
            chk($sformatf("v%0d_nob_d0", i), rdata_nob[31:0], 64'(tbl[i].nob_d0));
            chk($sformatf("v%0d_nob_b0", i), {63'h0, rbusy_nob[0]}, {63'h0, tbl[i].nob_b0});
            chk($sformatf("v%0d_noz_d0", i), rdata_noz[31:0], 64'(tbl[i].noz_d0));
            tick();
        end
        idle();

        // Register 0: hardwired in the default instance, ordinary in ZERO_REG=0.
        raddr = {5'd9, 5'd0};
        #1;
        chk("r0_def_data", rdata_def[31:0], 64'h0);
        chk("r0_def_busy", {63'h0, rbusy_def[0]}, 64'h0);
        chk("r0_noz_data", rdata_noz[31:0], 64'hFFFFFFFF);
        chk("r0_noz_busy", {63'h0, rbusy_noz[0]}, 64'h1);
        chk("r0_noz_any", {63'h0, any_noz}, 64'h1);
        chk("r9_def_final", rdata_def[63:32], 64'h99);
        tick();

        // Wide instance: fill r0..r7 with index*0x101, then read four ports at once.
        for (int i = 0; i < 8; i++) begin
            w_we0 = 1'b1;
            w_waddr0 = 3'(i);
            w_wdata0 = 16'(i * 257);
            tick();
        end
        w_we0 = 1'b0;
        sel[0] = 3'd1; sel[1] = 3'd4; sel[2] = 3'd6; sel[3] = 3'd7;
        w_raddr = {sel[3], sel[2], sel[1], sel[0]};
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wide_a_p%0d", k), 64'(w_rdata[k*16 +: 16]), 64'(sel[k] * 16'h0101));
        end
        chk("wide_rbusy", {60'h0, w_rbusy}, 64'h0);
        sel[0] = 3'd0; sel[1] = 3'd5; sel[2] = 3'd3; sel[3] = 3'd2;
        w_raddr = {sel[3], sel[2], sel[1], sel[0]};
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wide_b_p%0d", k), 64'(w_rdata[k*16 +: 16]), 64'(sel[k] * 16'h0101));
        end
        chk("wide_any", {63'h0, w_any}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
